// File: rtl/cim_pkg.sv
// rtl/cim_pkg.sv - shared widths and state encoding for the CIM weight-load controller
package cim_pkg;
    localparam int CIM_LANES  = 16;
    localparam int CIM_WBITS  = 12;
    localparam int CIM_NBLK   = 9;
    localparam int CIM_ROWW   = 192;
    localparam int CIM_LANE_W = $clog2(CIM_LANES);
    localparam int CIM_BLK_W  = $clog2(CIM_NBLK);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        WR     = 2'd1,
        SETTLE = 2'd2,
        FULL   = 2'd3
    } cim_state_t;
endpackage

// File: rtl/cim_row_pack.sv
// rtl/cim_row_pack.sv - 16-lane weight pack register with lane counter
module cim_row_pack
    import cim_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 w_valid,
    input  logic [CIM_WBITS-1:0] w_data,
    output logic                 accept,
    output logic                 lane15,
    output logic [CIM_ROWW-1:0]  row
);
    logic [CIM_LANE_W-1:0] lane_cnt;

    assign accept = en && w_valid;
    assign lane15 = accept && (lane_cnt == CIM_LANE_W'(CIM_LANES - 1));

    // The counter wraps to 0 after lane 15, so no explicit clear is needed on WR.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lane_cnt <= '0;
            row      <= '0;
        end else begin
            if (accept)
                row[lane_cnt*CIM_WBITS +: CIM_WBITS] <= w_data;
            if (clr)
                lane_cnt <= '0;
            else if (accept)
                lane_cnt <= lane_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/cim_wload_ctrl.sv
// rtl/cim_wload_ctrl.sv - packs weight stream into rows and ping-pongs the two CIM banks
module cim_wload_ctrl
    import cim_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush,
    input  logic                 w_valid,
    input  logic [CIM_WBITS-1:0] w_data,
    output logic                 w_ready,
    output logic [CIM_ROWW-1:0]  cim_D,
    output logic [CIM_NBLK-1:0]  cim_WA,
    output logic                 cim_cima,
    output logic                 act_bank,
    output logic                 act_valid,
    input  logic                 rel,
    output logic                 load_done
);
    cim_state_t           state, state_nxt;
    logic [CIM_BLK_W-1:0] blk_cnt;
    logic                 shadow_bank;
    logic                 accept, lane15;
    logic                 swap, swap_ok;

    assign w_ready  = (state == LOAD);
    assign cim_cima = ~shadow_bank;
    assign swap_ok  = !act_valid || rel;

    cim_row_pack u_pack (
        .clk     (clk),
        .rstn    (rstn),
        .en      (w_ready),
        .clr     (flush),
        .w_valid (w_valid),
        .w_data  (w_data),
        .accept  (accept),
        .lane15  (lane15),
        .row     (cim_D)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= LOAD;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        swap      = 1'b0;
        case (state)
            LOAD:    if (lane15) state_nxt = WR;
            WR:      state_nxt = (blk_cnt == CIM_BLK_W'(CIM_NBLK - 1)) ? SETTLE : LOAD;
            SETTLE: begin
                if (swap_ok) begin
                    swap      = 1'b1;
                    state_nxt = LOAD;
                end else begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (swap_ok) begin
                    swap      = 1'b1;
                    state_nxt = LOAD;
                end
            end
            default: state_nxt = LOAD;
        endcase
        // flush abandons the shadow load and cancels any pending swap
        if (flush) begin
            state_nxt = LOAD;
            swap      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            blk_cnt     <= '0;
            cim_WA      <= '0;
            shadow_bank <= 1'b0;
            act_bank    <= 1'b1;
            act_valid   <= 1'b0;
            load_done   <= 1'b0;
        end else begin
            if (flush || swap)
                blk_cnt <= '0;
            else if (state == WR)
                blk_cnt <= blk_cnt + 1'b1;

            // WA is launched on the edge that accepts lane 15 so it is high during WR only
            cim_WA <= (lane15 && !flush) ? (CIM_NBLK'(1) << blk_cnt) : '0;

            load_done <= swap;
            if (swap) begin
                act_bank    <= shadow_bank;
                shadow_bank <= act_bank;
                act_valid   <= 1'b1;
            end else if (rel) begin
                act_valid   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cim_wload_ctrl.sv
// tb/tb_cim_wload_ctrl.sv - scoreboard bench for the CIM weight-load controller
module tb_cim_wload_ctrl;
    import cim_pkg::*;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 flush = 1'b0;
    logic                 w_valid = 1'b0;
    logic [CIM_WBITS-1:0] w_data = '0;
    logic                 rel = 1'b0;
    logic                 w_ready;
    logic [CIM_ROWW-1:0]  cim_D;
    logic [CIM_NBLK-1:0]  cim_WA;
    logic                 cim_cima;
    logic                 act_bank;
    logic                 act_valid;
    logic                 load_done;

    cim_wload_ctrl dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .w_valid   (w_valid),
        .w_data    (w_data),
        .w_ready   (w_ready),
        .cim_D     (cim_D),
        .cim_WA    (cim_WA),
        .cim_cima  (cim_cima),
        .act_bank  (act_bank),
        .act_valid (act_valid),
        .rel       (rel),
        .load_done (load_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [CIM_NBLK-1:0] wa;
        logic [CIM_ROWW-1:0] d;
        logic                cima;
    } wr_t;

    wr_t  wr_q[$];
    logic swap_q[$];

    int n_checks = 0;
    int n_fail = 0;
    int swap_cnt = 0;
    int last_swap_cyc = 0;
    int first_cyc = 0;
    bit first_seen = 1'b0;

    logic [CIM_ROWW-1:0] m_row = '0;
    int   m_lane = 0;
    int   m_blk = 0;
    logic m_shadow = 1'b0;
    logic m_act = 1'b1;

    task automatic chk(input string tag, input logic [CIM_ROWW-1:0] obs, input logic [CIM_ROWW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_row = '0; m_lane = 0; m_blk = 0; m_shadow = 1'b0; m_act = 1'b1;
    endtask

    task automatic model_beat(input logic [CIM_WBITS-1:0] d);
        wr_t  e;
        logic tmp;
        m_row[m_lane*CIM_WBITS +: CIM_WBITS] = d;
        m_lane++;
        if (m_lane == CIM_LANES) begin
            e.wa   = CIM_NBLK'(1) << m_blk;
            e.d    = m_row;
            e.cima = ~m_shadow;
            wr_q.push_back(e);
            m_lane = 0;
            if (m_blk == CIM_NBLK - 1) begin
                swap_q.push_back(m_shadow);
                tmp = m_act; m_act = m_shadow; m_shadow = tmp;
                m_blk = 0;
            end else begin
                m_blk++;
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT writes a block or swaps banks.
    logic [CIM_NBLK-1:0] prev_wa = '0;
    wr_t  mon_e;
    logic mon_b;
    initial forever begin
        @(negedge clk);
        if (prev_wa != '0) chk("wa_gap", cim_WA, 0);
        if (cim_WA != '0) begin
            if (wr_q.size() == 0) begin
                chk("wa_unexpected", cim_WA, 0);
            end else begin
                mon_e = wr_q.pop_front();
                chk("wa", cim_WA, mon_e.wa);
                chk("row_d", cim_D, mon_e.d);
                chk("cima", cim_cima, mon_e.cima);
            end
        end
        if (load_done) begin
            swap_cnt++;
            last_swap_cyc = cyc;
            if (swap_q.size() == 0) begin
                chk("swap_unexpected", load_done, 0);
            end else begin
                mon_b = swap_q.pop_front();
                chk("swap_act_bank", act_bank, mon_b);
                chk("swap_act_valid", act_valid, 1);
            end
        end
        prev_wa = cim_WA;
    end

    task automatic send_beat(input logic [CIM_WBITS-1:0] d, input bit do_rel, input bit toggle);
        int waited = 0;
        bit acc = 1'b0;
        w_valid = 1'b1;
        w_data  = d;
        rel     = do_rel;
        while (!acc && waited < 100) begin
            @(negedge clk);
            acc = w_ready;
            @(posedge clk);
            #1;
            rel = 1'b0;
            waited++;
        end
        if (!acc) chk("beat_timeout", acc, 1);
        else begin
            if (!first_seen) begin
                first_cyc  = cyc;
                first_seen = 1'b1;
            end
            model_beat(d);
        end
        if (toggle) begin
            w_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_set(input int n, input bit ramp, input bit toggle, input int rel_at);
        first_seen = 1'b0;
        for (int k = 0; k < n; k++) begin
            send_beat(ramp ? CIM_WBITS'(k) : CIM_WBITS'($urandom), k == rel_at, toggle);
            if (k == rel_at) chk("rel_drop", act_valid, 0);
        end
        w_valid = 1'b0;
    endtask

    task automatic wait_swap(input int n0);
        int i = 0;
        while (swap_cnt == n0 && i < 400) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk("swap_seen", swap_cnt, n0 + 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_w_ready"}, w_ready, 1);
        chk({tag, "_wa"}, cim_WA, 0);
        chk({tag, "_d"}, cim_D, 0);
        chk({tag, "_cima"}, cim_cima, 1);
        chk({tag, "_act_bank"}, act_bank, 1);
        chk({tag, "_act_valid"}, act_valid, 0);
        chk({tag, "_load_done"}, load_done, 0);
    endtask

    int n0;
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        model_reset();
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Set 1: ramp data into bank 0, swap right after SETTLE
        n0 = swap_cnt;
        send_set(144, 1'b1, 1'b0, -1);
        wait_swap(n0);
        chk("set1_latency", last_swap_cyc - first_cyc, 153);
        chk("set1_act_bank", act_bank, 0);

        // Set 2: no release, controller must park in FULL and ignore held beats
        n0 = swap_cnt;
        send_set(144, 1'b0, 1'b0, -1);
        w_valid = 1'b1;
        w_data  = 12'habc;
        repeat (8) @(posedge clk);
        #1;
        w_valid = 1'b0;
        chk("full_w_ready", w_ready, 0);
        chk("full_no_swap", swap_cnt, n0);
        chk("full_act_valid", act_valid, 1);
        rel = 1'b1;
        @(posedge clk);
        #1;
        rel = 1'b0;
        chk("rel_swap_load_done", load_done, 1);
        chk("rel_swap_act_bank", act_bank, 1);
        wait_swap(n0);

        // Flush after 40 beats: no further writes, bank pointers untouched
        send_set(40, 1'b0, 1'b0, -1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        m_lane = 0;
        m_blk  = 0;
        chk("flush_q_empty", wr_q.size(), 0);
        repeat (20) @(posedge clk);
        #1;
        chk("flush_act_bank", act_bank, 1);
        chk("flush_act_valid", act_valid, 1);
        chk("flush_w_ready", w_ready, 1);

        // Reload after flush with rel during LOAD: swap at SETTLE, no FULL cycle
        n0 = swap_cnt;
        send_set(144, 1'b0, 1'b0, 20);
        wait_swap(n0);
        chk("relload_latency", last_swap_cyc - first_cyc, 153);
        chk("relload_act_bank", act_bank, 0);

        // Toggling valid: one idle cycle after every accepted beat
        rel = 1'b1;
        @(posedge clk);
        #1;
        rel = 1'b0;
        chk("idle_rel_drop", act_valid, 0);
        n0 = swap_cnt;
        send_set(144, 1'b0, 1'b1, -1);
        wait_swap(n0);
        chk("toggle_latency", last_swap_cyc - first_cyc, 288);
        chk("toggle_act_bank", act_bank, 1);

        // Asynchronous reset during block 5
        send_set(85, 1'b0, 1'b0, -1);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        chk("async_rst_q_empty", wr_q.size(), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        n0 = swap_cnt;
        send_set(144, 1'b0, 1'b0, -1);
        wait_swap(n0);
        chk("post_rst_latency", last_swap_cyc - first_cyc, 153);
        chk("post_rst_act_bank", act_bank, 0);

        repeat (4) @(posedge clk);
        #1;
        chk("end_wr_q_empty", wr_q.size(), 0);
        chk("end_swap_q_empty", swap_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
